// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: single pipeline stage with valid/ready handshake on both
// sides, flush-driven bubble insertion and a saturating downstream-stall counter.
//
// Build option:
//   PIPE_STAGE_REG_SKID_EN  undefined (default): one entry. in_ready is
//                           combinational from out_ready.
//                           defined: main + skid entries. in_ready comes
//                           straight from a flop, which breaks the ready path.
//
// Control bits are zeroed whenever their entry is empty. The payload keeps its
// last value so downstream sees no gating on the data bus.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    // Saturating increment for the stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Main entry: always the one presented downstream.
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [15:0]       stall_cnt_q,  stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid_q && out_ready;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    // Count cycles in which a held payload is refused downstream. Flush does
    // not touch this counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // The skid slot absorbs the one payload that can arrive in the cycle after
    // downstream stalls, so ready only needs to be known a cycle late.
    assign in_ready = !skid_valid_q;

    // Next-state and next-entry logic for the two-entry buffer.
    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            // Any simultaneous input is dropped; any simultaneous output is
            // already taken by downstream, so both entries simply empty.
            state_d      = ST_EMPTY;
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_ONE;
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                        main_ctrl_d  = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer) begin
                        state_d      = ST_TWO;
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                        skid_ctrl_d  = in_ctrl;
                    end else if (out_xfer) begin
                        state_d      = ST_EMPTY;
                        main_valid_d = 1'b0;
                        main_ctrl_d  = '0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_xfer) begin
                        state_d      = ST_ONE;
                        main_data_d  = skid_data_q;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = '0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_valid_d = 1'b0;
                    main_ctrl_d  = '0;
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = '0;
                end
            endcase
        end
    end

    // Skid entry and buffer state; reset discards any held payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

`else

    // Single entry: room exists if empty or if the held payload leaves now.
    assign in_ready = !main_valid_q || out_ready;

    // Next-entry logic for the single-entry register slice.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end
    end

`endif

    // Main entry and stall counter; reset clears every output immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (default 32-bit data, 16-bit ctrl).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [15:0]       stall_cnt;

    int n_assert;
    int n_fail;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 1'b0);

        // Reset state.
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,            32'd0);
        chk("rst_out_ctrl",  {16'b0, out_ctrl},   32'd0);
        chk("rst_stall_cnt", {16'b0, stall_cnt},  32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},   32'd1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back stream 0x11, 0x22, 0x33 with downstream always ready.
        drive(1'b1, 32'h11, 16'h1, 1'b1);
        tick();
        chk("s_valid0", {31'b0, out_valid}, 32'd1);
        chk("s_data0",  out_data,           32'h11);
        chk("s_ctrl0",  {16'b0, out_ctrl},  32'h1);
        drive(1'b1, 32'h22, 16'h2, 1'b1);
        tick();
        chk("s_valid1", {31'b0, out_valid}, 32'd1);
        chk("s_data1",  out_data,           32'h22);
        drive(1'b1, 32'h33, 16'h3, 1'b1);
        tick();
        chk("s_valid2", {31'b0, out_valid}, 32'd1);
        chk("s_data2",  out_data,           32'h33);
        chk("s_ctrl2",  {16'b0, out_ctrl},  32'h3);
        drive(1'b0, 32'h0, 16'h0, 1'b1);
        tick();
        chk("s_drain_valid", {31'b0, out_valid}, 32'd0);
        chk("s_drain_ctrl",  {16'b0, out_ctrl},  32'd0);
        chk("s_drain_data",  out_data,           32'h33);
        chk("s_stall",       {16'b0, stall_cnt}, 32'd0);

        // Hold 0xAA / ctrl 0x5 against a 3-cycle downstream stall.
        drive(1'b1, 32'hAA, 16'h5, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0);
`ifndef PIPE_STAGE_REG_SKID_EN
        #1;
        chk("h_in_ready_low", {31'b0, in_ready}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_valid", {31'b0, out_valid}, 32'd1);
            chk("h_data",  out_data,           32'hAA);
            chk("h_ctrl",  {16'b0, out_ctrl},  32'h5);
            chk("h_stall", {16'b0, stall_cnt}, i + 1);
        end
        out_ready = 1'b1;
        #1;
        chk("h_in_ready_high", {31'b0, in_ready}, 32'd1);
        tick();
        chk("h_release_valid", {31'b0, out_valid}, 32'd0);
        chk("h_release_stall", {16'b0, stall_cnt}, 32'd3);

        // Flush against a full stage with simultaneous input and output transfer.
        drive(1'b1, 32'h77, 16'h7, 1'b0);
        tick();
        chk("f_full_valid", {31'b0, out_valid}, 32'd1);
        chk("f_full_data",  out_data,           32'h77);
        drive(1'b1, 32'h99, 16'h9, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 1'b1);
        chk("f_valid", {31'b0, out_valid}, 32'd0);
        chk("f_ctrl",  {16'b0, out_ctrl},  32'd0);
        chk("f_data_hold", out_data,       32'h77);
        chk("f_stall_kept", {16'b0, stall_cnt}, 32'd3);
        tick();
        chk("f_no_ghost_valid", {31'b0, out_valid}, 32'd0);
        chk("f_no_ghost_data",  out_data,           32'h77);

`ifdef PIPE_STAGE_REG_SKID_EN
        // Two accepts into a stalled stage fill main then skid.
        drive(1'b1, 32'hA1, 16'h1, 1'b0);
        tick();
        chk("k_in_ready_one", {31'b0, in_ready}, 32'd1);
        chk("k_data_one",     out_data,          32'hA1);
        drive(1'b1, 32'hA2, 16'h2, 1'b0);
        tick();
        chk("k_in_ready_two", {31'b0, in_ready}, 32'd0);
        chk("k_data_two",     out_data,          32'hA1);
        drive(1'b0, 32'h0, 16'h0, 1'b1);
        #1;
        chk("k_in_ready_reg", {31'b0, in_ready}, 32'd0);
        tick();
        chk("k_second_valid", {31'b0, out_valid}, 32'd1);
        chk("k_second_data",  out_data,           32'hA2);
        chk("k_in_ready_back", {31'b0, in_ready}, 32'd1);
        tick();
        chk("k_empty_valid", {31'b0, out_valid}, 32'd0);
        // Bring the stall counter back to zero for the saturation section.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
`else
        // Bring the stall counter back to zero for the saturation section.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
`endif
        chk("sat_start", {16'b0, stall_cnt}, 32'd0);

        // Long stall: 0xFFFE stall cycles, then saturation.
        drive(1'b1, 32'h55, 16'hA, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0);
        repeat (65533) @(posedge clk);
        tick();
        chk("sat_fffe", {16'b0, stall_cnt}, 32'hFFFE);
        tick();
        chk("sat_ffff", {16'b0, stall_cnt}, 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", {16'b0, stall_cnt}, 32'hFFFF);
        chk("sat_data", out_data,           32'h55);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_valid",    {31'b0, out_valid}, 32'd0);
        chk("ar_data",     out_data,           32'd0);
        chk("ar_ctrl",     {16'b0, out_ctrl},  32'd0);
        chk("ar_stall",    {16'b0, stall_cnt}, 32'd0);
        chk("ar_in_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ar_after_valid", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
